// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel gradient magnitude over a raster-order grayscale frame.
// Define SOBEL_BINARIZE_EN to threshold the magnitude against SOBEL_THRESHOLD to 0 / full-scale.
module sobel_stream #(
  parameter int unsigned PIXEL_WIDTH     = 8,
  parameter int unsigned IMG_WIDTH       = 64,
  parameter int unsigned IMG_HEIGHT      = 64,
  parameter int unsigned SOBEL_THRESHOLD = 64
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   start_i,
  input  logic [PIXEL_WIDTH-1:0] in_px_gray_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  output logic [PIXEL_WIDTH-1:0] out_px_sobel_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic                   frame_done_o
);

  localparam int unsigned XW = $clog2(IMG_WIDTH);
  localparam int unsigned YW = $clog2(IMG_HEIGHT);
  localparam int unsigned SW = PIXEL_WIDTH + 3;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StFill  = 2'd1;
  localparam logic [1:0] StRun   = 2'd2;
  localparam logic [1:0] StFlush = 2'd3;

`ifdef SOBEL_BINARIZE_EN
  localparam bit BinarizeEn = 1'b1;
`else
  localparam bit BinarizeEn = 1'b0;
`endif

  logic [1:0]             state_q, state_d;
  logic [XW-1:0]          x_q, x_d;
  logic [YW-1:0]          y_q, y_d;
  logic                   out_valid_q, out_valid_d;
  logic [PIXEL_WIDTH-1:0] out_px_q, out_px_d;
  logic                   frame_done_q, frame_done_d;

  logic in_xfer;
  logic last_col;
  logic last_px;
  logic emit;

  assign in_ready_o = ((state_q == StFill) || (state_q == StRun)) &&
                      (!out_valid_q || out_ready_i);
  assign in_xfer    = in_valid_i && in_ready_o;
  assign last_col   = (x_q == XW'(IMG_WIDTH - 1));
  assign last_px    = last_col && (y_q == YW'(IMG_HEIGHT - 1));
  assign emit       = in_xfer && (x_q >= XW'(2)) && (y_q >= YW'(2));

  // Line buffers: top holds line y-2, mid holds line y-1, both indexed by column.
  logic [PIXEL_WIDTH-1:0] lb_top_q [IMG_WIDTH];
  logic [PIXEL_WIDTH-1:0] lb_mid_q [IMG_WIDTH];

  // Window columns x-2 and x-1 are registered; column x is the live column below.
  logic [PIXEL_WIDTH-1:0] win_q [3][2];
  logic [PIXEL_WIDTH-1:0] col_new [3];

  assign col_new[0] = lb_top_q[x_q];
  assign col_new[1] = lb_mid_q[x_q];
  assign col_new[2] = in_px_gray_i;

  // Buffer contents are rewritten during FILL before use, so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (in_xfer) begin
      lb_top_q[x_q] <= col_new[1];
      lb_mid_q[x_q] <= in_px_gray_i;
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= win_q[r][1];
        win_q[r][1] <= col_new[r];
      end
    end
  end

  function automatic logic signed [SW-1:0] ext(input logic [PIXEL_WIDTH-1:0] v);
    return $signed({3'b000, v});
  endfunction

  logic signed [SW-1:0]   gx, gy;
  logic [SW-1:0]          abs_gx, abs_gy;
  logic [SW:0]            mag;
  logic [PIXEL_WIDTH-1:0] mag_sat;
  logic [PIXEL_WIDTH-1:0] result;

  always_comb begin
    gx = (ext(col_new[0]) + (ext(col_new[1]) <<< 1) + ext(col_new[2])) -
         (ext(win_q[0][0]) + (ext(win_q[1][0]) <<< 1) + ext(win_q[2][0]));
    gy = (ext(win_q[2][0]) + (ext(win_q[2][1]) <<< 1) + ext(col_new[2])) -
         (ext(win_q[0][0]) + (ext(win_q[0][1]) <<< 1) + ext(col_new[0]));
    abs_gx  = gx[SW-1] ? -gx : gx;
    abs_gy  = gy[SW-1] ? -gy : gy;
    mag     = {1'b0, abs_gx} + {1'b0, abs_gy};
    mag_sat = (|mag[SW:PIXEL_WIDTH]) ? '1 : mag[PIXEL_WIDTH-1:0];
    if (BinarizeEn) begin
      result = (32'(mag_sat) >= SOBEL_THRESHOLD) ? '1 : '0;
    end else begin
      result = mag_sat;
    end
  end

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    out_valid_d  = out_valid_q;
    out_px_d     = out_px_q;
    frame_done_d = 1'b0;

    // Input is only accepted when the output slot is free or draining this cycle.
    if (emit) begin
      out_valid_d = 1'b1;
      out_px_d    = result;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end

    if (in_xfer) begin
      if (last_col) begin
        x_d = '0;
        y_d = last_px ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end

    case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StFill;
          x_d     = '0;
          y_d     = '0;
        end
      end
      StFill: begin
        if (in_xfer && (x_q == '0) && (y_q == YW'(2))) state_d = StRun;
      end
      StRun: begin
        if (in_xfer && last_px) state_d = StFlush;
      end
      StFlush: begin
        if (!out_valid_q || out_ready_i) begin
          state_d      = StIdle;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      x_q          <= '0;
      y_q          <= '0;
      out_valid_q  <= 1'b0;
      out_px_q     <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      out_valid_q  <= out_valid_d;
      out_px_q     <= out_px_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign out_valid_o    = out_valid_q;
  assign out_px_sobel_o = out_px_q;
  assign frame_done_o   = frame_done_q;

endmodule

// File: tb/tb_sobel_stream.sv
// Self-checking bench for sobel_stream: directed edge/saturation frames plus randomized traffic.
module tb_sobel_stream;

  localparam int PW   = 8;
  localparam int W    = 4;
  localparam int H    = 4;
  localparam int THR  = 30;
  localparam int NOUT = (W - 2) * (H - 2);
  localparam int PMAX = (1 << PW) - 1;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          start_i;
  logic [PW-1:0] in_px_gray_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [PW-1:0] out_px_sobel_o;
  logic          out_valid_o;
  logic          out_ready_i;
  logic          frame_done_o;

  always #5 clk_i = ~clk_i;

  sobel_stream #(
    .PIXEL_WIDTH     (PW),
    .IMG_WIDTH       (W),
    .IMG_HEIGHT      (H),
    .SOBEL_THRESHOLD (THR)
  ) u_dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .start_i        (start_i),
    .in_px_gray_i   (in_px_gray_i),
    .in_valid_i     (in_valid_i),
    .in_ready_o     (in_ready_o),
    .out_px_sobel_o (out_px_sobel_o),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .frame_done_o   (frame_done_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int pix [H][W];
  int exp_q [$];
  int out_cnt;
  int done_cnt;
  bit mon_en;
  int rdy_mode;
  int stall_left;
  bit prev_stall;
  int prev_px;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // Reference: window rows are lines y-2..y, columns x-2..x, straight from the frame array.
  function automatic int sobel_ref(input int x, input int y);
    int gx, gy, mag;
    gx = (pix[y-2][x] + 2 * pix[y-1][x] + pix[y][x]) -
         (pix[y-2][x-2] + 2 * pix[y-1][x-2] + pix[y][x-2]);
    gy = (pix[y][x-2] + 2 * pix[y][x-1] + pix[y][x]) -
         (pix[y-2][x-2] + 2 * pix[y-2][x-1] + pix[y-2][x]);
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    if (mag > PMAX) mag = PMAX;
`ifdef SOBEL_BINARIZE_EN
    mag = (mag >= THR) ? PMAX : 0;
`endif
    return mag;
  endfunction

  task automatic fill_frame(input int pattern);
    exp_q.delete();
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        case (pattern)
          0:       pix[y][x] = 100;
          1:       pix[y][x] = (x < 2) ? 0 : 10;
          2:       pix[y][x] = (x < 2) ? 0 : 255;
          default: pix[y][x] = int'($urandom_range(0, 255));
        endcase
      end
    end
    for (int y = 2; y < H; y++) begin
      for (int x = 2; x < W; x++) exp_q.push_back(sobel_ref(x, y));
    end
  endtask

  // Output-side monitor; transfers are sampled mid-cycle, ahead of the edge that commits them.
  always @(negedge clk_i) begin
    if (mon_en) begin
      if (prev_stall) begin
        check_val("hold_valid", int'(out_valid_o), 1);
        check_val("hold_px", int'(out_px_sobel_o), prev_px);
      end
      if (out_valid_o && !out_ready_i) check_val("stall_in_ready", int'(in_ready_o), 0);
      if (out_valid_o && out_ready_i) begin
        out_cnt++;
        check_val("expected_pending", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) check_val("px", int'(out_px_sobel_o), exp_q.pop_front());
      end
      if (frame_done_o) done_cnt++;
      prev_stall = out_valid_o && !out_ready_i;
      prev_px    = int'(out_px_sobel_o);
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Downstream ready: always ready, random, or a 5-cycle stall on the first valid output.
  initial begin
    out_ready_i = 1'b1;
    forever begin
      @(posedge clk_i);
      #1;
      case (rdy_mode)
        1: out_ready_i = ($urandom_range(0, 2) != 0);
        2: begin
          if (out_valid_o && stall_left > 0) begin
            out_ready_i = 1'b0;
            stall_left--;
          end else begin
            out_ready_i = 1'b1;
          end
        end
        default: out_ready_i = 1'b1;
      endcase
    end
  end

  task automatic send_px(input int v, input bit gaps);
    int cyc;
    bit acc;
    if (gaps) begin
      in_valid_i   = 1'b0;
      in_px_gray_i = PW'($urandom);
      tick(int'($urandom_range(0, 2)));
    end
    in_valid_i   = 1'b1;
    in_px_gray_i = PW'(v);
    cyc = 0;
    acc = 1'b0;
    while (!acc && cyc < 100) begin
      @(negedge clk_i);
      acc = in_ready_o;
      @(posedge clk_i);
      #1;
      cyc++;
    end
    check_val("in_accept", int'(acc), 1);
    in_valid_i = 1'b0;
  endtask

  task automatic run_frame(input string name, input int pattern, input bit gaps, input int mode,
                           input bit mid_start);
    int cyc;
    fill_frame(pattern);
    out_cnt    = 0;
    done_cnt   = 0;
    stall_left = 5;
    rdy_mode   = mode;
    mon_en     = 1'b1;
    start_i    = 1'b1;
    tick(1);
    start_i    = 1'b0;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        if (mid_start && y == 2 && x == 2) begin
          start_i = 1'b1;
          tick(1);
          start_i = 1'b0;
        end
        send_px(pix[y][x], gaps);
      end
    end
    cyc = 0;
    while (done_cnt == 0 && cyc < 200) begin
      tick(1);
      cyc++;
    end
    tick(4);
    rdy_mode = 0;
    check_val({name, "_done_pulses"}, done_cnt, 1);
    check_val({name, "_outputs"}, out_cnt, NOUT);
    check_val({name, "_left_over"}, exp_q.size(), 0);
    check_val({name, "_idle_in_ready"}, int'(in_ready_o), 0);
  endtask

  initial begin
    reset_i      = 1'b1;
    start_i      = 1'b0;
    in_valid_i   = 1'b0;
    in_px_gray_i = '0;
    mon_en       = 1'b0;
    rdy_mode     = 0;
    stall_left   = 0;
    out_cnt      = 0;
    done_cnt     = 0;
    prev_stall   = 1'b0;
    prev_px      = 0;
    tick(3);
    check_val("rst_in_ready", int'(in_ready_o), 0);
    check_val("rst_out_valid", int'(out_valid_o), 0);
    check_val("rst_out_px", int'(out_px_sobel_o), 0);
    check_val("rst_frame_done", int'(frame_done_o), 0);
    reset_i = 1'b0;
    tick(2);

    run_frame("flat", 0, 1'b0, 0, 1'b0);
    run_frame("step10", 1, 1'b0, 0, 1'b0);
    run_frame("step255", 2, 1'b0, 0, 1'b0);
    run_frame("stall", 3, 1'b0, 2, 1'b0);

    // Abandon a frame in RUN with a result pending, then reset.
    mon_en = 1'b0;
    fill_frame(3);
    start_i = 1'b1;
    tick(1);
    start_i = 1'b0;
    for (int i = 0; i < 11; i++) send_px(pix[i / W][i % W], 1'b0);
    reset_i = 1'b1;
    tick(1);
    reset_i = 1'b0;
    check_val("midrst_out_valid", int'(out_valid_o), 0);
    check_val("midrst_in_ready", int'(in_ready_o), 0);
    check_val("midrst_out_px", int'(out_px_sobel_o), 0);
    check_val("midrst_frame_done", int'(frame_done_o), 0);
    exp_q.delete();
    tick(2);
    run_frame("after_reset", 3, 1'b1, 1, 1'b0);

    run_frame("start_in_run", 3, 1'b0, 0, 1'b1);

    // Pixels offered while idle must be ignored.
    mon_en  = 1'b1;
    out_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      in_valid_i   = 1'b1;
      in_px_gray_i = PW'($urandom);
      @(negedge clk_i);
      check_val("idle_in_ready", int'(in_ready_o), 0);
      @(posedge clk_i);
      #1;
    end
    in_valid_i = 1'b0;
    tick(3);
    check_val("idle_outputs", out_cnt, 0);
    run_frame("post_idle", 3, 1'b0, 0, 1'b0);

    for (int f = 0; f < 20; f++) run_frame("random", 3, 1'b1, 1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
